parking_lane_counter: RTL and testbench
=======================================

// Module: parking_lane_counter
// PURPOSE
//  Multi-lane parking-lot controller. Each of LANES entry/exit gates has two
//  optical sensors (a = outer, b = inner). Per lane, a direction-decoding FSM
//  turns sensor sequences into one-cycle enter/exit pulses. A shared saturating
//  occupancy counter adds those pulses, drives full/empty flags and flags
//  over-/under-flow. It sits between the raw sensor pins and the display and
//  barrier logic.
// PARAMETERS
//  LANES     2   number of gates; each gate has its own sensor pair and FSM
//  CAPACITY  50  maximum number of parked cars; CAPACITY >= 1
//  CNT_W     8   width of the count; must satisfy 2**CNT_W > CAPACITY
// PORTS
//  clk            in   1       single system clock, rising edge
//  rst_n          in   1       asynchronous reset, active-low
//  a              in   LANES   outer sensor per lane, async, 1 = beam blocked
//  b              in   LANES   inner sensor per lane, async, 1 = beam blocked
//  enter_pulse    out  LANES   1-cycle pulse: a car completed entry on lane i
//  exit_pulse     out  LANES   1-cycle pulse: a car completed exit on lane i
//  count          out  CNT_W   current occupancy, 0..CAPACITY
//  full           out  1       count == CAPACITY
//  empty          out  1       count == 0
//  overflow_err   out  1       1-cycle pulse: an entry was clamped at CAPACITY
//  underflow_err  out  1       1-cycle pulse: an exit was clamped at 0
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - all FSMs go to IDLE; synchronizer flops clear to 0
//   - count=0, empty=1, full=0; all pulses and error outputs 0
//  Input path: each a[i]/b[i] passes through a 2-flop synchronizer. The FSM
//   acts on the synced value 2 cycles after the input edge.
//  Per-lane FSM, input pair s={a,b}:
//   IDLE  : 10->IN_A   01->OUT_B   00,11->IDLE
//   IN_A  : 10->IN_A   11->IN_AB   00,01->IDLE
//   IN_AB : 11->IN_AB  01->IN_B    10->IN_A    00->IDLE
//   IN_B  : 01->IN_B   11->IN_AB   10->IDLE    00->IDLE + enter
//   OUT_B : 01->OUT_B  11->OUT_BA  00,10->IDLE
//   OUT_BA: 11->OUT_BA 10->OUT_A   01->OUT_B   00->IDLE
//   OUT_A : 10->OUT_A  11->OUT_BA  01->IDLE    00->IDLE + exit
//  The pulse is registered. It is high for exactly 1 cycle, in the cycle after
//   the FSM samples 00 in IN_B/OUT_A, i.e. 3 clk edges after the raw 00 edge.
//  Aborted or reversed sequences (car backs out) produce no pulse.
//   11 from IDLE is ignored.
//  Counter: n_in = popcount(enter_pulse), n_out = popcount(exit_pulse).
//   - count updates on the same edge that raises the pulses, so the new count
//     is visible in the same cycle as the pulses
//   - next = count + n_in - n_out, computed signed, CNT_W+2 bits wide
//   - next > CAPACITY: count=CAPACITY, overflow_err=1 for that cycle
//   - next < 0: count=0, underflow_err=1 for that cycle
//   - simultaneous entry and exit cancel, including at full or empty:
//     no error, no change
//  full and empty are registered, coincident with count.
//  Lanes are independent. A full lot does not block FSM decoding;
//   barrier gating is external.
//  Reset asserted mid-sequence: FSM returns to IDLE and any pending pulse is
//   lost. After release, sensors must pass through 00 before a new sequence.
// TESTING
//  1 reset: rst_n=0 with sensors toggling -> count=0, empty=1, no pulses;
//    release mid-cycle -> still idle
//  2 lane0 a,b = 10,11,01,00 (each held 4 cycles) -> enter_pulse=01 for 1
//    cycle, 3 edges after the 00 edge; count 0->1, empty 1->0
//  3 lane1 b,a = 01,11,10,00 starting at count=1 -> exit_pulse=10 once,
//    count=0, empty=1; repeat at count=0 -> underflow_err=1, count stays 0
//  4 lane0 10,11,10,00 (backs out) -> no pulse, count unchanged
//  5 CAPACITY=3, count=3: lane0 completes entry -> overflow_err=1, count=3,
//    full=1; lane0 entry plus lane1 exit in the same cycle -> count=3, no error
//  6 LANES=2, both lanes complete entry in the same cycle from count=0 ->
//    enter_pulse=11, count=2; assert rst_n=0 in lane IN_AB -> no pulse

Source files
------------

// File: rtl/parking_lane_counter_if.sv
// Sensor and occupancy bundle for the parking lane counter.
// Handshake note: there is no valid/ready pair here. The sensor inputs are
// level signals that are sampled every cycle. Every output is a registered
// level or a one-cycle pulse that the consumer must catch on the cycle it is
// high. dbg_state exposes each lane FSM, packed 3 bits per lane with lane 0
// in the LSBs.
interface parking_lane_counter_if #(
    parameter int LANES = 2,
    parameter int CNT_W = 8
);
    logic [LANES-1:0]   a;
    logic [LANES-1:0]   b;
    logic [LANES-1:0]   enter_pulse;
    logic [LANES-1:0]   exit_pulse;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               empty;
    logic               overflow_err;
    logic               underflow_err;
    logic [3*LANES-1:0] dbg_state;

    // Sensor side: drives the raw beam signals and observes the results.
    modport master (
        output a, b,
        input  enter_pulse, exit_pulse, count, full, empty,
               overflow_err, underflow_err, dbg_state
    );

    // Controller side.
    modport slave (
        input  a, b,
        output enter_pulse, exit_pulse, count, full, empty,
               overflow_err, underflow_err, dbg_state
    );
endinterface

// File: rtl/parking_lane_counter.sv
// Multi-lane parking lot controller. Each lane has a 2-flop synchronizer and
// a direction-decoding FSM. The FSM turns outer/inner beam sequences into
// registered one-cycle enter/exit pulses. A shared saturating counter tracks
// occupancy and reports full/empty plus clamped over/underflow.
module parking_lane_counter #(
    parameter int LANES    = 2,
    parameter int CAPACITY = 50,
    parameter int CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    parking_lane_counter_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IN_A   = 3'd1,
        IN_AB  = 3'd2,
        IN_B   = 3'd3,
        OUT_B  = 3'd4,
        OUT_BA = 3'd5,
        OUT_A  = 3'd6
    } lane_state_e;

    localparam logic signed [CNT_W+1:0] CAP_S  = (CNT_W+2)'(CAPACITY);
    localparam logic signed [CNT_W+1:0] ZERO_S = '0;
    localparam logic        [CNT_W-1:0] CAP_C  = CNT_W'(CAPACITY);

    logic [LANES-1:0] a_s1_q, a_s2_q, b_s1_q, b_s2_q;
    lane_state_e      state_q [LANES];
    lane_state_e      state_d [LANES];
    logic [LANES-1:0] enter_d, exit_d, enter_q, exit_q;

    logic signed [CNT_W+1:0] next_s;
    logic [CNT_W-1:0] count_d, count_q;
    logic             full_d, full_q, empty_d, empty_q;
    logic             ovf_d, ovf_q, unf_d, unf_q;

    // Two-flop synchronizers for the asynchronous beam sensors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_s1_q <= '0;
            a_s2_q <= '0;
            b_s1_q <= '0;
            b_s2_q <= '0;
        end else begin
            a_s1_q <= bus.a;
            a_s2_q <= a_s1_q;
            b_s1_q <= bus.b;
            b_s2_q <= b_s1_q;
        end
    end

    // Per-lane direction decoding on the synchronized pair {a,b}.
    always_comb begin
        enter_d = '0;
        exit_d  = '0;
        for (int i = 0; i < LANES; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                IDLE: begin
                    case ({a_s2_q[i], b_s2_q[i]})
                        2'b10:   state_d[i] = IN_A;
                        2'b01:   state_d[i] = OUT_B;
                        default: state_d[i] = IDLE;   // 11 is ignored
                    endcase
                end
                IN_A: begin
                    case ({a_s2_q[i], b_s2_q[i]})
                        2'b10:   state_d[i] = IN_A;
                        2'b11:   state_d[i] = IN_AB;
                        default: state_d[i] = IDLE;
                    endcase
                end
                IN_AB: begin
                    case ({a_s2_q[i], b_s2_q[i]})
                        2'b11:   state_d[i] = IN_AB;
                        2'b01:   state_d[i] = IN_B;
                        2'b10:   state_d[i] = IN_A;
                        default: state_d[i] = IDLE;
                    endcase
                end
                IN_B: begin
                    case ({a_s2_q[i], b_s2_q[i]})
                        2'b01:   state_d[i] = IN_B;
                        2'b11:   state_d[i] = IN_AB;
                        2'b10:   state_d[i] = IDLE;   // reversed, no pulse
                        default: begin
                            state_d[i] = IDLE;
                            enter_d[i] = 1'b1;
                        end
                    endcase
                end
                OUT_B: begin
                    case ({a_s2_q[i], b_s2_q[i]})
                        2'b01:   state_d[i] = OUT_B;
                        2'b11:   state_d[i] = OUT_BA;
                        default: state_d[i] = IDLE;
                    endcase
                end
                OUT_BA: begin
                    case ({a_s2_q[i], b_s2_q[i]})
                        2'b11:   state_d[i] = OUT_BA;
                        2'b10:   state_d[i] = OUT_A;
                        2'b01:   state_d[i] = OUT_B;
                        default: state_d[i] = IDLE;
                    endcase
                end
                OUT_A: begin
                    case ({a_s2_q[i], b_s2_q[i]})
                        2'b10:   state_d[i] = OUT_A;
                        2'b11:   state_d[i] = OUT_BA;
                        2'b01:   state_d[i] = IDLE;   // reversed, no pulse
                        default: begin
                            state_d[i] = IDLE;
                            exit_d[i]  = 1'b1;
                        end
                    endcase
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    // Lane state registers and registered direction pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) state_q[i] <= IDLE;
            enter_q <= '0;
            exit_q  <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) state_q[i] <= state_d[i];
            enter_q <= enter_d;
            exit_q  <= exit_d;
        end
    end

    // Saturating occupancy update. It uses the pulses being registered this
    // edge, so the count moves together with the pulses. The sum is signed
    // and two bits wider than the count, so a clamp in either direction is
    // detected before it wraps.
    always_comb begin
        next_s = $signed({2'b00, count_q});
        for (int i = 0; i < LANES; i++) begin
            next_s = next_s + $signed({{(CNT_W+1){1'b0}}, enter_d[i]})
                            - $signed({{(CNT_W+1){1'b0}}, exit_d[i]});
        end
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        count_d = next_s[CNT_W-1:0];
        if (next_s > CAP_S) begin
            count_d = CAP_C;
            ovf_d   = 1'b1;
        end else if (next_s < ZERO_S) begin
            count_d = '0;
            unf_d   = 1'b1;
        end
        full_d  = (count_d == CAP_C);
        empty_d = (count_d == '0);
    end

    // Occupancy, flag and error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Drive the bundle outputs, including the packed per-lane debug state.
    always_comb begin
        bus.enter_pulse   = enter_q;
        bus.exit_pulse    = exit_q;
        bus.count         = count_q;
        bus.full          = full_q;
        bus.empty         = empty_q;
        bus.overflow_err  = ovf_q;
        bus.underflow_err = unf_q;
        bus.dbg_state     = '0;
        for (int i = 0; i < LANES; i++) bus.dbg_state[3*i +: 3] = state_q[i];
    end

endmodule

// File: tb/tb_parking_lane_counter.sv
// Directed bench for parking_lane_counter. It uses two lanes and a capacity
// of 3 so that saturation is reachable. Sensor phases are held for 4 cycles.
// After the final 00 phase is applied, six cycles of outputs are captured at
// the negative edges. Index 2 is the cycle three edges after the 00 edge.
module tb_parking_lane_counter;

    localparam int LANES    = 2;
    localparam int CAPACITY = 3;
    localparam int CNT_W    = 8;

    localparam logic [5:0] ENTRY = 6'b10_11_01;
    localparam logic [5:0] EXIT  = 6'b01_11_10;
    localparam logic [5:0] BACK  = 6'b10_11_10;
    localparam logic [5:0] HOLD  = 6'b10_11_11;
    localparam logic [5:0] NONE  = 6'b00_00_00;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [1:0]       ent_h [6];
    logic [1:0]       ext_h [6];
    logic [CNT_W-1:0] cnt_h [6];
    logic             ovf_h [6];
    logic             unf_h [6];
    logic             full_h[6];
    logic             emp_h [6];

    parking_lane_counter_if #(.LANES(LANES), .CNT_W(CNT_W)) bus ();

    parking_lane_counter #(
        .LANES(LANES), .CAPACITY(CAPACITY), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply three 4-cycle phases per lane. Each vector lists {a,b} pairs,
    // first phase in the MSBs.
    task automatic run3(input logic [5:0] s0, input logic [5:0] s1);
        for (int k = 0; k < 3; k++) begin
            bus.a = {s1[5-2*k], s0[5-2*k]};
            bus.b = {s1[4-2*k], s0[4-2*k]};
            repeat (4) @(negedge clk);
        end
    endtask

    // Release both lanes to 00 and capture six cycles of outputs.
    task automatic finish_zero();
        bus.a = '0;
        bus.b = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            ent_h[k]  = bus.enter_pulse;
            ext_h[k]  = bus.exit_pulse;
            cnt_h[k]  = bus.count;
            ovf_h[k]  = bus.overflow_err;
            unf_h[k]  = bus.underflow_err;
            full_h[k] = bus.full;
            emp_h[k]  = bus.empty;
        end
    endtask

    // OR of every pulse captured in the last window.
    function automatic logic [3:0] any_pulse();
        logic [3:0] acc;
        acc = '0;
        for (int k = 0; k < 6; k++) acc = acc | {ext_h[k], ent_h[k]};
        return acc;
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.a    = '0;
        bus.b    = '0;

        // Reset held while the sensors toggle.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus.a = 2'($urandom_range(0, 3));
            bus.b = 2'($urandom_range(0, 3));
        end
        @(negedge clk);
        check_eq("rst_count", 32'(bus.count), 32'd0);
        check_eq("rst_empty", 32'(bus.empty), 32'd1);
        check_eq("rst_full",  32'(bus.full), 32'd0);
        check_eq("rst_pulses", 32'({bus.exit_pulse, bus.enter_pulse}), 32'd0);
        check_eq("rst_errs", 32'({bus.overflow_err, bus.underflow_err}), 32'd0);
        check_eq("rst_state", 32'(bus.dbg_state), 32'd0);
        bus.a = '0;
        bus.b = '0;
        #3 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("post_rel_state", 32'(bus.dbg_state), 32'd0);
        check_eq("post_rel_count", 32'(bus.count), 32'd0);

        // Lane 0 entry with exact pulse timing.
        run3(ENTRY, NONE);
        finish_zero();
        check_eq("ent_edge1", 32'(ent_h[0]), 32'd0);
        check_eq("ent_edge2", 32'(ent_h[1]), 32'd0);
        check_eq("ent_edge3", 32'(ent_h[2]), 32'b01);
        check_eq("ent_edge4", 32'(ent_h[3]), 32'd0);
        check_eq("ent_cnt_before", 32'(cnt_h[1]), 32'd0);
        check_eq("ent_cnt_after",  32'(cnt_h[2]), 32'd1);
        check_eq("ent_empty_before", 32'(emp_h[1]), 32'd1);
        check_eq("ent_empty_after",  32'(emp_h[2]), 32'd0);
        check_eq("ent_no_exit", 32'(ext_h[2]), 32'd0);

        // Lane 1 exit, then the same exit again at empty.
        run3(NONE, EXIT);
        finish_zero();
        check_eq("ext_pulse", 32'(ext_h[2]), 32'b10);
        check_eq("ext_pulse_end", 32'(ext_h[3]), 32'd0);
        check_eq("ext_count", 32'(cnt_h[2]), 32'd0);
        check_eq("ext_empty", 32'(emp_h[2]), 32'd1);
        check_eq("ext_no_unf", 32'(unf_h[2]), 32'd0);
        run3(NONE, EXIT);
        finish_zero();
        check_eq("unf_pulse", 32'(ext_h[2]), 32'b10);
        check_eq("unf_err", 32'(unf_h[2]), 32'd1);
        check_eq("unf_err_end", 32'(unf_h[3]), 32'd0);
        check_eq("unf_count", 32'(cnt_h[2]), 32'd0);

        // Lane 0 backs out.
        run3(BACK, NONE);
        finish_zero();
        check_eq("back_no_pulse", 32'(any_pulse()), 32'd0);
        check_eq("back_count", 32'(cnt_h[5]), 32'd0);

        // Fill to capacity, then overflow, then entry+exit cancel at full.
        for (int k = 0; k < 3; k++) begin
            run3(ENTRY, NONE);
            finish_zero();
            check_eq("fill_count", 32'(cnt_h[2]), 32'(k + 1));
            check_eq("fill_no_ovf", 32'(ovf_h[2]), 32'd0);
            check_eq("fill_full", 32'(full_h[2]), (k == 2) ? 32'd1 : 32'd0);
        end
        run3(ENTRY, NONE);
        finish_zero();
        check_eq("ovf_pulse", 32'(ent_h[2]), 32'b01);
        check_eq("ovf_err", 32'(ovf_h[2]), 32'd1);
        check_eq("ovf_err_end", 32'(ovf_h[3]), 32'd0);
        check_eq("ovf_count", 32'(cnt_h[2]), 32'd3);
        check_eq("ovf_full", 32'(full_h[2]), 32'd1);
        run3(ENTRY, EXIT);
        finish_zero();
        check_eq("cancel_ent", 32'(ent_h[2]), 32'b01);
        check_eq("cancel_ext", 32'(ext_h[2]), 32'b10);
        check_eq("cancel_count", 32'(cnt_h[2]), 32'd3);
        check_eq("cancel_errs", 32'({ovf_h[2], unf_h[2]}), 32'd0);
        check_eq("cancel_full", 32'(full_h[2]), 32'd1);

        // Drain to zero, then both lanes enter in the same cycle.
        for (int k = 0; k < 3; k++) begin
            run3(NONE, EXIT);
            finish_zero();
            check_eq("drain_count", 32'(cnt_h[2]), 32'(2 - k));
        end
        run3(ENTRY, ENTRY);
        finish_zero();
        check_eq("dual_pulse", 32'(ent_h[2]), 32'b11);
        check_eq("dual_count", 32'(cnt_h[2]), 32'd2);
        check_eq("dual_no_ovf", 32'(ovf_h[2]), 32'd0);

        // Reset while lane 0 is in IN_AB; the pending entry is lost.
        run3(HOLD, NONE);
        check_eq("hold_state", 32'(bus.dbg_state[2:0]), 32'd2);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("midrst_state", 32'(bus.dbg_state), 32'd0);
        check_eq("midrst_count", 32'(bus.count), 32'd0);
        check_eq("midrst_empty", 32'(bus.empty), 32'd1);
        @(negedge clk);
        #3 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("midrst_11_ignored", 32'(bus.dbg_state), 32'd0);
        bus.a = 2'b00;
        bus.b = 2'b01;
        repeat (4) @(negedge clk);
        finish_zero();
        check_eq("midrst_no_pulse", 32'(any_pulse()), 32'd0);
        check_eq("midrst_count_end", 32'(cnt_h[5]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
